// File: rtl/boot_loader.sv
// Boot loader: parses a framed byte-stream image into 32-bit memory writes,
// verifies an XOR checksum, then releases the memory port to the CPU.
module boot_loader #(
    parameter logic [7:0] SYNC_BYTE     = 8'h5A,
    parameter bit         LOAD_ON_RESET = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:31] cpu_address,
    input  logic [0:3]   cpu_write_en,
    input  logic [0:31]  cpu_data_in,
    output logic [15:31] mem_address,
    output logic [0:3]   mem_write_en,
    output logic [0:31]  mem_data_in,
    output logic         cpu_active,
    output logic         done,
    output logic         error
);

    typedef enum logic [3:0] {
        SYNC, ADDR2, ADDR1, ADDR0, CNT1, CNT0, DATA, WRITE, CSUM, RUN, ERROR
    } state_t;

    state_t         state_q, state_d;
    logic [15:31]   addr_q, addr_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [0:31]    asm_q, asm_d;
    logic [1:0]     idx_q, idx_d;
    logic [7:0]     csum_q, csum_d;
    logic           done_q, done_d;
    logic           active_q, active_d;
    logic           error_q, error_d;
    logic           xfer;

    assign xfer       = in_valid && in_ready;
    assign done       = done_q;
    assign cpu_active = active_q;
    assign error      = error_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= LOAD_ON_RESET ? SYNC : RUN;
            addr_q   <= '0;
            cnt_q    <= '0;
            asm_q    <= '0;
            idx_q    <= '0;
            csum_q   <= '0;
            done_q   <= LOAD_ON_RESET ? 1'b0 : 1'b1;
            active_q <= LOAD_ON_RESET ? 1'b0 : 1'b1;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            idx_q    <= idx_d;
            csum_q   <= csum_d;
            done_q   <= done_d;
            active_q <= active_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        asm_d        = asm_q;
        idx_d        = idx_q;
        csum_d       = csum_q;
        done_d       = done_q;
        active_d     = active_q;
        error_d      = error_q;
        in_ready     = 1'b1;
        mem_address  = '0;
        mem_write_en = '0;
        mem_data_in  = '0;

        case (state_q)
            SYNC: begin
                if (xfer && in_data == SYNC_BYTE) begin
                    csum_d  = '0;
                    state_d = ADDR2;
                end
            end
            ADDR2: begin
                if (xfer) begin
                    addr_d[15] = in_data[0];
                    state_d    = ADDR1;
                end
            end
            ADDR1: begin
                if (xfer) begin
                    addr_d[16:23] = in_data;
                    state_d       = ADDR0;
                end
            end
            ADDR0: begin
                if (xfer) begin
                    addr_d[24:31] = in_data;
                    state_d       = CNT1;
                end
            end
            CNT1: begin
                if (xfer) begin
                    cnt_d[15:8] = in_data;
                    state_d     = CNT0;
                end
            end
            CNT0: begin
                if (xfer) begin
                    cnt_d[7:0] = in_data;
                    idx_d      = '0;
                    state_d    = ({cnt_q[15:8], in_data} == 16'd0) ? CSUM : DATA;
                end
            end
            // First byte of a word ends up in bits 0:7 after four shifts.
            DATA: begin
                if (xfer) begin
                    asm_d  = {asm_q[8:31], in_data};
                    csum_d = csum_q ^ in_data;
                    if (idx_q == 2'd3) begin
                        idx_d   = '0;
                        state_d = WRITE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            WRITE: begin
                in_ready     = 1'b0;
                mem_address  = addr_q;
                mem_write_en = 4'hF;
                mem_data_in  = asm_q;
                addr_d       = addr_q + 17'd1;
                cnt_d        = cnt_q - 16'd1;
                state_d      = (cnt_q == 16'd1) ? CSUM : DATA;
            end
            CSUM: begin
                if (xfer) begin
                    if (in_data == csum_q) begin
                        done_d   = 1'b1;
                        active_d = 1'b1;
                        state_d  = RUN;
                    end else begin
                        error_d = 1'b1;
                        state_d = ERROR;
                    end
                end
            end
            ERROR: begin
                if (xfer && in_data == SYNC_BYTE) begin
                    error_d = 1'b0;
                    csum_d  = '0;
                    state_d = ADDR2;
                end
            end
            RUN: begin
                in_ready     = 1'b0;
                mem_address  = cpu_address;
                mem_write_en = cpu_write_en;
                mem_data_in  = cpu_data_in;
            end
            default: state_d = SYNC;
        endcase
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: one loader instance plus a bypassed
// (LOAD_ON_RESET=0) instance, with a byte-lane memory model on the loader port.
module tb_boot_loader;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic [15:31] cpu_address = 17'h5;
    logic [0:3]   cpu_write_en = 4'hF;
    logic [0:31]  cpu_data_in = 32'hDEADBEEF;

    logic         in_ready_a, cpu_active_a, done_a, error_a;
    logic [15:31] mem_address_a;
    logic [0:3]   mem_write_en_a;
    logic [0:31]  mem_data_in_a;

    logic         in_ready_b, cpu_active_b, done_b, error_b;
    logic [15:31] mem_address_b;
    logic [0:3]   mem_write_en_b;
    logic [0:31]  mem_data_in_b;

    int compared = 0;
    int mismatched = 0;
    int wr_count = 0;
    int stray_count = 0;
    int ready_low = 0;
    int wr_base;
    int rl_base;
    logic [0:31] mem_model [0:131071];

    logic [119:0] frame1 = 120'h5A_00_00_20_00_02_12_34_56_78_9A_BC_DE_F0_00;
    logic [119:0] frame4 = 120'h5A_01_FF_FF_00_02_11_22_33_44_55_66_77_88_88;

    always #5 clock = ~clock;

    boot_loader #(.SYNC_BYTE(8'h5A), .LOAD_ON_RESET(1'b1)) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
        .cpu_address(cpu_address), .cpu_write_en(cpu_write_en), .cpu_data_in(cpu_data_in),
        .mem_address(mem_address_a), .mem_write_en(mem_write_en_a), .mem_data_in(mem_data_in_a),
        .cpu_active(cpu_active_a), .done(done_a), .error(error_a)
    );

    boot_loader #(.SYNC_BYTE(8'h5A), .LOAD_ON_RESET(1'b0)) dut_bypass (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
        .cpu_address(cpu_address), .cpu_write_en(cpu_write_en), .cpu_data_in(cpu_data_in),
        .mem_address(mem_address_b), .mem_write_en(mem_write_en_b), .mem_data_in(mem_data_in_b),
        .cpu_active(cpu_active_b), .done(done_b), .error(error_b)
    );

    // Memory model and load-phase bookkeeping, sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++)
                if (mem_write_en_a[i] === 1'b1)
                    mem_model[mem_address_a][8*i +: 8] = mem_data_in_a[8*i +: 8];
            if (!cpu_active_a) begin
                if (mem_write_en_a === 4'hF) wr_count++;
                else if (mem_write_en_a !== 4'h0) stray_count++;
                if (!in_ready_a) ready_low++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    // Present one byte and hold it until the loader takes it.
    task automatic applyStimulus(input logic [7:0] b);
        int guard = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready_a && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("in_ready_stall", {31'd0, in_ready_a}, 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic sendPacked(input logic [255:0] f, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            applyStimulus(f[8*(n-1-i) +: 8]);
        end
    endtask

    task automatic applyReset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, {31'd0, in_ready_a}, 32'd1);
        checkOutput({tag, "_wen"}, {28'd0, mem_write_en_a}, 32'd0);
        checkOutput({tag, "_addr"}, {15'd0, mem_address_a}, 32'd0);
        checkOutput({tag, "_wdata"}, mem_data_in_a, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done_a}, 32'd0);
        checkOutput({tag, "_active"}, {31'd0, cpu_active_a}, 32'd0);
        checkOutput({tag, "_error"}, {31'd0, error_a}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        checkResetValues("rst");
        checkOutput("byp_in_ready", {31'd0, in_ready_b}, 32'd0);
        checkOutput("byp_done", {31'd0, done_b}, 32'd1);
        checkOutput("byp_active", {31'd0, cpu_active_b}, 32'd1);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("load_cpu_blocked", {28'd0, mem_write_en_a}, 32'd0);

        // Bypassed instance passes CPU traffic straight through.
        cpu_address = 17'h10; cpu_write_en = 4'b0011; cpu_data_in = 32'hAABBCCDD;
        #1;
        checkOutput("byp_addr", {15'd0, mem_address_b}, 32'h10);
        checkOutput("byp_wen", {28'd0, mem_write_en_b}, 32'h3);
        checkOutput("byp_wdata", mem_data_in_b, 32'hAABBCCDD);
        cpu_address = 17'h5; cpu_write_en = 4'hF; cpu_data_in = 32'hDEADBEEF;
        @(negedge clock);

        $display("[TB] test 1: basic two-word frame");
        wr_base = wr_count; rl_base = ready_low;
        sendPacked({136'd0, frame1[119:8]}, 14, 1'b0);
        checkOutput("t1_done_before_csum", {31'd0, done_a}, 32'd0);
        applyStimulus(frame1[7:0]);
        checkOutput("t1_done", {31'd0, done_a}, 32'd1);
        checkOutput("t1_active", {31'd0, cpu_active_a}, 32'd1);
        checkOutput("t1_error", {31'd0, error_a}, 32'd0);
        checkOutput("t1_in_ready_run", {31'd0, in_ready_a}, 32'd0);
        idle(2);
        checkOutput("t1_writes", wr_count - wr_base, 32'd2);
        checkOutput("t1_ready_low", ready_low - rl_base, 32'd2);
        checkOutput("t1_mem20", mem_model[17'h20], 32'h12345678);
        checkOutput("t1_mem21", mem_model[17'h21], 32'h9ABCDEF0);
        checkOutput("t1_stray", stray_count, 32'd0);

        $display("[TB] test 6: CPU pass-through in RUN");
        cpu_address = 17'h10; cpu_write_en = 4'b0011; cpu_data_in = 32'hAABBCCDD;
        in_data = 8'h5A; in_valid = 1'b1;
        #1;
        checkOutput("t6_addr", {15'd0, mem_address_a}, 32'h10);
        checkOutput("t6_wen", {28'd0, mem_write_en_a}, 32'h3);
        checkOutput("t6_wdata", mem_data_in_a, 32'hAABBCCDD);
        checkOutput("t6_in_ready", {31'd0, in_ready_a}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        checkOutput("t6_mem_lanes23", {16'd0, mem_model[17'h10][16:31]}, 32'hCCDD);
        checkOutput("t6_done_held", {31'd0, done_a}, 32'd1);
        in_valid = 1'b0;
        cpu_address = 17'h5; cpu_write_en = 4'hF; cpu_data_in = 32'hDEADBEEF;

        $display("[TB] test 2: bad checksum then empty retry frame");
        applyReset();
        wr_base = wr_count;
        sendPacked({136'd0, frame1[119:8], 8'h01}, 15, 1'b0);
        checkOutput("t2_error", {31'd0, error_a}, 32'd1);
        checkOutput("t2_active", {31'd0, cpu_active_a}, 32'd0);
        checkOutput("t2_done", {31'd0, done_a}, 32'd0);
        checkOutput("t2_in_ready", {31'd0, in_ready_a}, 32'd1);
        idle(2);
        checkOutput("t2_writes", wr_count - wr_base, 32'd2);
        wr_base = wr_count;
        applyStimulus(8'h5A);
        checkOutput("t2_error_cleared", {31'd0, error_a}, 32'd0);
        sendPacked(256'h00_00_40_00_00_00, 6, 1'b0);
        checkOutput("t2_retry_done", {31'd0, done_a}, 32'd1);
        checkOutput("t2_retry_active", {31'd0, cpu_active_a}, 32'd1);
        idle(2);
        checkOutput("t2_retry_writes", wr_count - wr_base, 32'd0);

        $display("[TB] test 3: leading junk and gaps");
        applyReset();
        wr_base = wr_count;
        sendPacked({112'd0, 24'h00FF13, frame1}, 18, 1'b1);
        checkOutput("t3_done", {31'd0, done_a}, 32'd1);
        idle(2);
        checkOutput("t3_writes", wr_count - wr_base, 32'd2);
        checkOutput("t3_mem20", mem_model[17'h20], 32'h12345678);
        checkOutput("t3_mem21", mem_model[17'h21], 32'h9ABCDEF0);

        $display("[TB] test 4: address wrap");
        applyReset();
        sendPacked({136'd0, frame4}, 15, 1'b0);
        checkOutput("t4_done", {31'd0, done_a}, 32'd1);
        idle(2);
        checkOutput("t4_mem1ffff", mem_model[17'h1FFFF], 32'h11223344);
        checkOutput("t4_mem0", mem_model[17'h0], 32'h55667788);

        $display("[TB] test 5: reset mid-word");
        applyReset();
        wr_base = wr_count;
        sendPacked(256'h5A_00_00_20_00_02_12_34, 8, 1'b0);
        reset = 1'b1;
        #1;
        checkResetValues("t5_in_reset");
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkResetValues("t5_after_reset");
        idle(3);
        checkOutput("t5_no_partial_write", wr_count - wr_base, 32'd0);
        sendPacked({136'd0, frame1}, 15, 1'b0);
        checkOutput("t5_done", {31'd0, done_a}, 32'd1);
        idle(2);
        checkOutput("t5_writes", wr_count - wr_base, 32'd2);
        checkOutput("t5_mem20", mem_model[17'h20], 32'h12345678);
        checkOutput("t5_mem21", mem_model[17'h21], 32'h9ABCDEF0);
        checkOutput("t5_stray", stray_count, 32'd0);

        checkOutput("byp_in_ready_end", {31'd0, in_ready_b}, 32'd0);
        checkOutput("byp_active_end", {31'd0, cpu_active_b}, 32'd1);
        checkOutput("byp_error_end", {31'd0, error_b}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Sits between an external byte stream (UART receiver or bench driver) and the word-wide memory port shared with the CPU.
- After reset, holds the CPU inactive and owns the memory write port.
- Parses a framed load image, writes it into memory as 32-bit words, and verifies a checksum.
- On success, asserts cpu_active and hands the memory address and write path to the CPU.

Parameters:
SYNC_BYTE, 8'h5A, frame start marker.
LOAD_ON_RESET, 1, 1 = enter load mode after reset; 0 = go straight to RUN (loader bypassed).

Ports:
clock  input  1  system clock, all state on posedge.
reset  input  1  asynchronous, active-high.
in_data  input  8  stream byte.
in_valid  input  1  in_data valid.
in_ready  output  1  loader accepts the byte this cycle; a transfer occurs when in_valid && in_ready.
cpu_address  input  [15:31]  CPU word address.
cpu_write_en  input  [0:3]  CPU byte-lane write enables (lane 0 = bits 0:7).
cpu_data_in  input  [0:31]  CPU write data.
mem_address  output  [15:31]  to memory.
mem_write_en  output  [0:3]  to memory.
mem_data_in  output  [0:31]  to memory.
cpu_active  output  1  CPU run enable.
done  output  1  load completed with good checksum.
error  output  1  checksum mismatch.

Behaviour:
- Reset is decided: reset, asynchronous, active-high; clock is clock.
- Reset values: state = SYNC, or RUN if LOAD_ON_RESET=0. in_ready=1, except 0 in RUN. mem_write_en=0, mem_address=0, mem_data_in=0, error=0. done=0 and cpu_active=0, except both 1 when LOAD_ON_RESET=0. Internal checksum, word counter and byte index are 0.
- Frame format: SYNC_BYTE, then ADDR2/ADDR1/ADDR0 (24 bits, big-endian, low 17 bits used, upper 7 ignored), then CNT1/CNT0 (16-bit word count), then 4*count data bytes (big-endian, first byte = bits 0:7), then CSUM (XOR of data bytes only).
- States: SYNC, ADDR2, ADDR1, ADDR0, CNT1, CNT0, DATA, WRITE, CSUM, RUN, ERROR.
- SYNC: bytes other than SYNC_BYTE are consumed and discarded. SYNC_BYTE advances to ADDR2 and clears the checksum.
- ADDR*/CNT*: one byte each, accepted on transfer.
- After CNT0: count==0 goes to CSUM; otherwise goes to DATA.
- DATA: bytes shift into a 32-bit assembly register and XOR into the checksum. The 4th byte goes to WRITE.
- WRITE: exactly one cycle. in_ready=0, mem_write_en=4'hF, mem_address=current address, mem_data_in=assembled word; memory captures on that cycle's posedge. Then address increments modulo 2^17 (1FFFF wraps to 00000) and the counter decrements. Next state is CSUM if the counter reaches 0, else DATA.
- Outside WRITE in load states: mem_write_en=0, and CPU writes are blocked.
- CSUM: a byte equal to the checksum goes to RUN, with done=1 and cpu_active=1 registered, visible the cycle after the transfer. A mismatch goes to ERROR with error=1.
- ERROR: in_ready=1, cpu_active stays 0. Non-sync bytes are discarded. SYNC_BYTE clears error, clears the checksum and goes to ADDR2 (retry).
- RUN: terminal until reset. in_ready=0, and stream bytes are ignored. mem_address, mem_write_en and mem_data_in are combinationally cpu_address, cpu_write_en and cpu_data_in.
- In all non-RUN states, CPU inputs are ignored.
- Gaps (in_valid=0) may occur anywhere; state holds.
- Reset mid-frame aborts immediately. A partially assembled word is never written, and words already written remain in memory.

Test Plan:
1. Stream 5A 00 00 20 00 02 12 34 56 78 9A BC DE F0 00 -> write 12345678 at 0x20 and 9ABCDEF0 at 0x21, each a single 4'hF pulse. in_ready low for exactly those 2 cycles. done=1 and cpu_active=1 one cycle after CSUM; error=0.
2. Same frame with CSUM=01 -> both words written, error=1, cpu_active=0. Then send 5A 00 00 40 00 00 00 -> error clears, no writes, done=1.
3. Bytes 00 FF 13 before 5A, plus random in_valid gaps in test 1 -> identical writes; leading bytes discarded.
4. Addr 01 FF FF (upper bits ignored), count 2 -> writes land at 0x1FFFF then 0x00000.
5. Assert reset after the 2nd data byte of a word, then send the full test-1 frame -> no write before reset completes. After reset all outputs are at reset values, and the final memory matches test 1.
6. In RUN, drive cpu_address=0x0010, cpu_write_en=4'b0011, cpu_data_in=AABBCCDD -> passes to memory the same cycle, bytes 2:3 become CC DD; stream input shows in_ready=0. With LOAD_ON_RESET=0, this holds from the first cycle after reset.
